gelato_burst_arbiter: RTL and testbench
=======================================

// Module: gelato_burst_arbiter
// PURPOSE
//  Shares one downstream valid/ready channel among 2**PORT_NUM_WIDTH requesters.
//  Arbitration is round-robin and burst-locked: once a requester wins, it keeps the channel until its last beat.
//  Sits in front of shared resources such as a memory request port or writeback bus.
//  Keeps a beat counter so an unterminated burst cannot hold the channel forever.
// PARAMETERS
//  PORT_NUM_WIDTH  2   log2 of requester count; N = 2**PORT_NUM_WIDTH
//  DATA_WIDTH      32  payload width per beat
//  MAX_BURST       4   max beats per grant (>=1); beat MAX_BURST is forced to act as last
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           asynchronous active-low reset
//  req_valid     in   N           per-requester beat valid
//  req_last      in   N           per-requester last-beat flag
//  req_data      in   N*DATA_W    payloads; port i occupies [i*DATA_W +: DATA_W]
//  req_ready     out  N           per-requester beat accepted
//  out_valid     out  1           downstream beat valid
//  out_last      out  1           downstream last beat (includes forced last)
//  out_data      out  DATA_W      downstream payload
//  out_port      out  PORT_NUM_W  index of the requester that owns out_data
//  out_ready     in   1           downstream ready
//  grant_active  out  1           1 while in GRANT state
//  err_overflow  out  1           sticky flag: a burst exceeded MAX_BURST
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, prio_q=0, owner_q=0, beat_cnt_q=0, err_overflow=0.
//   - Outputs are forced: out_valid=0, req_ready=0, grant_active=0, out_port=0.
//  State IDLE:
//   - No beats are forwarded: out_valid=0, req_ready=0.
//   - If any req_valid bit is set, owner_d is the first set index scanning prio_q, prio_q+1, ... modulo N.
//   - Go to GRANT with owner_q=owner_d, beat_cnt_q=0. This costs one arbitration bubble cycle per grant.
//  State GRANT:
//   - Forwarding: out_valid=req_valid[owner_q], out_data=req_data[owner_q], out_port=owner_q.
//   - Ready: req_ready[owner_q]=out_ready; all other req_ready bits are 0.
//   - A beat transfers when out_valid && out_ready. Each transfer increments beat_cnt_q.
//   - out_last = req_last[owner_q] | (beat_cnt_q == MAX_BURST-1).
//   - If the owner drops valid mid-burst, stay in GRANT with out_valid=0 and no count; other requesters stay blocked.
//  Burst end (transfer with out_last=1):
//   - Next cycle: IDLE, prio_q=owner_q+1 (wraps modulo N), beat_cnt_q=0.
//  Forced last (transfer with beat_cnt_q==MAX_BURST-1 and req_last[owner_q]==0):
//   - Also sets err_overflow=1; the flag stays set until reset.
//  Width and timing:
//   - beat_cnt_q is clog2(MAX_BURST+1) bits; prio and owner arithmetic wraps at PORT_NUM_WIDTH bits.
//   - Forwarding is combinational in GRANT (0-cycle latency). State, prio_q, owner_q, beat_cnt_q and err are registered.
//  Edge cases:
//   - Requesters not granted see req_ready=0 regardless of their req_valid.
//   - A single-beat request (last=1) costs 2 cycles: IDLE then GRANT.
//   - Reset asserted mid-burst aborts the burst immediately; there is no partial-burst recovery.
// TESTING (N=4, DATA_WIDTH=32, MAX_BURST=4)
//  - Reset, then req_valid=4'b1111 held -> cycle 1: IDLE, out_valid=0; cycle 2: grant_active=1, out_port=0.
//  - All 4 single-beat (last=1), out_ready=1 -> out_port sequence 0,1,2,3,0, one beat every 2 cycles.
//  - Port 2 sends 3 beats (last on beat 3) while port 0 is valid -> port 0 req_ready=0 throughout; next grant=0 (3 idle).
//  - Port 1 mid-burst, out_ready=0 for 3 cycles -> out_data stable, req_ready[1]=0, beat_cnt_q unchanged.
//  - Port 1 sends 5 beats, all last=0 -> 4th beat has out_last=1, err_overflow=1 stays high, next prio_q=2.
//  - rst_n pulsed low mid-burst -> out_valid, req_ready, grant_active fall the same cycle; next grant restarts at port 0.

Source files
------------

// File: rtl/gelato_burst_arbiter.sv
// Round-robin, burst-locked arbiter sharing one valid/ready channel among 2**PORT_NUM_WIDTH requesters.
// The winner keeps the channel until its last beat; a beat counter forces a last after MAX_BURST beats.
module gelato_burst_arbiter #(
  parameter int PORT_NUM_WIDTH = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BURST      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [(2**PORT_NUM_WIDTH)-1:0]             req_valid,
  input  logic [(2**PORT_NUM_WIDTH)-1:0]             req_last,
  input  logic [(2**PORT_NUM_WIDTH)*DATA_WIDTH-1:0]  req_data,
  output logic [(2**PORT_NUM_WIDTH)-1:0]             req_ready,
  output logic                                       out_valid,
  output logic                                       out_last,
  output logic [DATA_WIDTH-1:0]                      out_data,
  output logic [PORT_NUM_WIDTH-1:0]                  out_port,
  input  logic                                       out_ready,
  output logic                                       grant_active,
  output logic                                       err_overflow
);

  localparam int N  = 2 ** PORT_NUM_WIDTH;
  localparam int PW = PORT_NUM_WIDTH;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BEAT_CAP = CW'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_prio;
  logic [PW-1:0]   w_prio_nxt;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   w_owner_nxt;
  logic [CW-1:0]   r_beat_cnt;
  logic [CW-1:0]   w_beat_cnt_nxt;
  logic            r_err;
  logic            w_err_nxt;

  logic [PW-1:0]   w_pick;
  logic            w_any_valid;
  logic            w_own_valid;
  logic            w_own_last;
  logic            w_at_cap;
  logic            w_xfer;
  logic            w_burst_end;

  // Round-robin pick: first valid requester at or after r_prio, wrapping at PW bits.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found  = 1'b0;
    w_pick = r_prio;
    for (int k = 0; k < N; k++) begin
      idx = r_prio + PW'(k);
      if (!found && req_valid[idx]) begin
        w_pick = idx;
        found  = 1'b1;
      end
    end
  end

  assign w_any_valid = |req_valid;
  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_at_cap    = (r_beat_cnt == BEAT_CAP);
  assign w_xfer      = (r_state == ST_GRANT) && w_own_valid && out_ready;
  assign w_burst_end = w_own_last || w_at_cap;

  // Payload and port index follow the current owner; out_valid qualifies them.
  assign out_data = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
  assign out_port = r_owner;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_prio_nxt     = r_prio;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_err_nxt      = r_err;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    req_ready      = '0;
    grant_active   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt    = ST_GRANT;
          w_owner_nxt    = w_pick;
          w_beat_cnt_nxt = '0;
        end
      end

      ST_GRANT: begin
        grant_active       = 1'b1;
        out_valid          = w_own_valid;
        out_last           = w_burst_end;
        req_ready[r_owner] = out_ready;
        if (w_xfer) begin
          if (w_burst_end) begin
            w_state_nxt    = ST_IDLE;
            w_prio_nxt     = r_owner + 1'b1;
            w_beat_cnt_nxt = '0;
            // A cap-forced last without the requester's own last flag is an overrun.
            if (w_at_cap && !w_own_last) begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_prio     <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign err_overflow = r_err;

endmodule

// File: tb/tb_gelato_burst_arbiter.sv
// Directed and randomized bench for gelato_burst_arbiter (N=4, DATA_WIDTH=32, MAX_BURST=4),
// compared cycle by cycle against a beat-counting reference model.
module tb_gelato_burst_arbiter;

  localparam int PW = 2;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic            out_last;
  logic [DW-1:0]   out_data;
  logic [PW-1:0]   out_port;
  logic            out_ready;
  logic            grant_active;
  logic            err_overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: "busy" while a requester holds the channel, beats counted from 1.
  bit m_busy;
  bit m_err;
  int m_owner;
  int m_prio;
  int m_beats;

  int xfer_ports[$];
  int exp_seq[5] = '{0, 1, 2, 3, 0};

  gelato_burst_arbiter #(
    .PORT_NUM_WIDTH(PW),
    .DATA_WIDTH    (DW),
    .MAX_BURST     (MB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_data    (out_data),
    .out_port    (out_port),
    .out_ready   (out_ready),
    .grant_active(grant_active),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_err   = 1'b0;
    m_owner = 0;
    m_prio  = 0;
    m_beats = 0;
  endfunction

  task automatic check_outputs();
    logic         exp_valid;
    logic [N-1:0] exp_ready;
    exp_valid = m_busy && req_valid[m_owner];
    exp_ready = '0;
    if (m_busy && out_ready) exp_ready[m_owner] = 1'b1;
    check("out_valid", out_valid, exp_valid);
    check("req_ready", req_ready, exp_ready);
    check("grant_active", grant_active, m_busy);
    check("err_overflow", err_overflow, m_err);
    if (m_busy) begin
      check("out_port", out_port, m_owner);
      check("out_last", out_last, req_last[m_owner] || (m_beats + 1 == MB));
    end
    if (exp_valid) check("out_data", out_data, req_data[m_owner*DW +: DW]);
  endtask

  task automatic model_update();
    if (!m_busy) begin
      if (|req_valid) begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[(m_prio + k) % N]) begin
            m_owner = (m_prio + k) % N;
            break;
          end
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (req_valid[m_owner] && out_ready) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin
        if (!req_last[m_owner]) m_err = 1'b1;
        m_busy  = 1'b0;
        m_prio  = (m_owner + 1) % N;
        m_beats = 0;
      end
    end
  endtask

  // One clock cycle: compare mid-cycle, advance the model, land 1 time unit after the next edge.
  task automatic tick();
    #3;
    check_outputs();
    if (out_valid && out_ready) xfer_ports.push_back(int'(out_port));
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    req_valid = v;
    req_last  = l;
    out_ready = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom();
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_grant_active", grant_active, 1'b0);
    check("rst_out_port", out_port, 2'd0);
    check("rst_err", err_overflow, 1'b0);
    rst_n = 1'b1;

    // All four single-beat requesters: bubble then grant, ports served 0,1,2,3,0.
    xfer_ports.delete();
    drive(4'b1111, 4'b1111, 1'b1);
    tick();
    check("c2_grant_active", grant_active, 1'b1);
    check("c2_out_port", out_port, 2'd0);
    for (int i = 0; i < 9; i++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      tick();
    end
    check("seq_len", xfer_ports.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < xfer_ports.size()) check("seq_port", xfer_ports[i], exp_seq[i]);
    end

    // Move priority to port 2, then a 3-beat burst from port 2 while port 0 waits.
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    drive(4'b0010, 4'b0010, 1'b1);
    tick();
    tick();
    drive(4'b0101, 4'b0000, 1'b1);
    tick();
    tick();
    tick();
    drive(4'b0101, 4'b0100, 1'b1);
    check("p2_owner", out_port, 2'd2);
    tick();
    drive(4'b0001, 4'b0001, 1'b1);
    tick();
    check("next_grant_p0", out_port, 2'd0);
    check("next_grant_active", grant_active, 1'b1);
    tick();

    // Port 1 mid-burst with downstream stalled for 3 cycles.
    drive(4'b0010, 4'b0000, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 4'b0000, 1'b0);
      req_data[1*DW +: DW] = 32'h5EED_0002;
      tick();
      check("stall_data", out_data, 32'h5EED_0002);
      check("stall_ready", req_ready, 4'b0000);
    end
    drive(4'b0010, 4'b0010, 1'b1);
    tick();

    // Port 1 tries 5 beats without last: beat 4 forced last, err sticks, priority moves to 2.
    drive(4'b0010, 4'b0000, 1'b1);
    tick();
    tick();
    tick();
    tick();
    check("forced_last", out_last, 1'b1);
    check("err_before_force", err_overflow, 1'b0);
    tick();
    drive(4'b1110, 4'b0000, 1'b1);
    tick();
    check("err_sticky", err_overflow, 1'b1);
    check("prio_after_force", out_port, 2'd2);
    tick();

    // Reset mid-burst: outputs drop immediately, next grant restarts at port 0.
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_req_ready", req_ready, 4'b0000);
    check("mid_rst_grant", grant_active, 1'b0);
    check("mid_rst_err", err_overflow, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1);
    tick();
    check("restart_p0", out_port, 2'd0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      for (int i = 0; i < N; i++) begin
        v[i] = ($urandom_range(0, 9) < 6);
        l[i] = ($urandom_range(0, 9) < 3);
      end
      drive(v, l, ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
